// File: rtl/data_pattern_gen.sv
// Sensor-model pattern generator: re-times fval/lval by two clocks and drives a
// multi-channel test pattern whose mode and header-skip are latched per frame.
module data_pattern_gen #(
  parameter int unsigned CHANNEL_NUM = 4,
  parameter int unsigned DATA_WIDTH  = 12,
  parameter int unsigned FCNT_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [2:0]                        iv_mode,
  input  logic [7:0]                        iv_skip_line,
  input  logic [DATA_WIDTH-1:0]             iv_const,
  input  logic                              i_fval,
  input  logic                              i_lval,
  output logic                              o_fval,
  output logic                              o_lval,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_dout,
  output logic [FCNT_WIDTH-1:0]             ov_frame_cnt
);

  localparam logic [2:0]  ModeConst        = 3'd0;
  localparam logic [2:0]  ModePixInc       = 3'd1;
  localparam logic [2:0]  ModePixIncNoFval = 3'd2;
  localparam logic [2:0]  ModeLineInc      = 3'd3;
  localparam logic [2:0]  ModeFrameInc     = 3'd4;
  localparam logic [2:0]  ModeLfsr         = 3'd5;
  localparam logic [15:0] LfsrSeed         = 16'hACE1;
  localparam logic [15:0] LfsrPoly         = 16'hB400;
  localparam int unsigned DoutW            = DATA_WIDTH * CHANNEL_NUM;

  logic                  fval_d1_q, lval_d1_q, fval_d2_q, lval_d2_q;
  logic                  prime_q, prime_d, armed_q, armed_d;
  logic [2:0]            mode_q, mode_d;
  logic [7:0]            skip_q, skip_d, line_cnt_q, line_cnt_d;
  logic [15:0]           pix_cnt_q, pix_cnt_d;
  logic [31:0]           frm_pix_q, frm_pix_d;
  logic [FCNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d, fcnt_lat_q, fcnt_lat_d;
  logic [15:0]           lfsr_q [CHANNEL_NUM];
  logic [15:0]           lfsr_d [CHANNEL_NUM];
  logic [DoutW-1:0]      dout_q, dout_d;

  logic                  frame_start, frame_end, line_end, act;
  logic [2:0]            mode_eff;
  logic [7:0]            skip_eff, line_eff, line_rel;
  logic [15:0]           pix_eff, lfsr_eff;
  logic [31:0]           frm_eff, pix_lin;
  logic [FCNT_WIDTH-1:0] fcnt_eff;
  logic [DATA_WIDTH-1:0] line_val;

  always_comb begin
    frame_start = armed_q & fval_d1_q & ~fval_d2_q;
    frame_end   = armed_q & ~fval_d1_q & fval_d2_q;
    line_end    = ~lval_d1_q & lval_d2_q;

    // prime_q marks that fval_d1 holds a real input sample, so a frame that was
    // already running across reset release cannot arm the generator.
    prime_d = 1'b1;
    armed_d = armed_q | (prime_q & ~fval_d1_q);

    // Values latched at frame start already apply on the frame-start cycle itself.
    mode_eff = frame_start ? iv_mode      : mode_q;
    skip_eff = frame_start ? iv_skip_line : skip_q;
    line_eff = frame_start ? 8'd0         : line_cnt_q;
    pix_eff  = frame_start ? 16'd0        : pix_cnt_q;
    frm_eff  = (frame_start && iv_mode != ModePixIncNoFval) ? 32'd0 : frm_pix_q;
    fcnt_eff = frame_start ? frame_cnt_q  : fcnt_lat_q;

    act = armed_q & fval_d1_q & lval_d1_q & (line_eff >= skip_eff);

    mode_d      = mode_eff;
    skip_d      = skip_eff;
    fcnt_lat_d  = fcnt_eff;
    line_cnt_d  = (line_end && !frame_start && line_cnt_q != 8'hFF) ? line_cnt_q + 8'd1
                                                                    : line_eff;
    pix_cnt_d   = line_end ? 16'd0 : pix_eff + 16'(lval_d1_q);
    frm_pix_d   = frm_eff + 32'(act);
    frame_cnt_d = frame_cnt_q + FCNT_WIDTH'(frame_end);

    line_rel = line_eff - skip_eff;
    line_val = DATA_WIDTH'({line_rel, pix_eff[3:0]});

    dout_d   = '0;
    lfsr_eff = '0;
    pix_lin  = '0;
    for (int ch = 0; ch < int'(CHANNEL_NUM); ch++) begin
      lfsr_eff   = frame_start ? (LfsrSeed ^ 16'(ch)) : lfsr_q[ch];
      lfsr_d[ch] = act ? ((lfsr_eff >> 1) ^ (lfsr_eff[0] ? LfsrPoly : 16'h0000)) : lfsr_eff;
      pix_lin    = frm_eff * CHANNEL_NUM + 32'(ch);
      if (act) begin
        case (mode_eff)
          ModeConst:        dout_d[ch*DATA_WIDTH +: DATA_WIDTH] = iv_const;
          ModePixInc,
          ModePixIncNoFval: dout_d[ch*DATA_WIDTH +: DATA_WIDTH] = pix_lin[DATA_WIDTH-1:0];
          ModeLineInc:      dout_d[ch*DATA_WIDTH +: DATA_WIDTH] = line_val;
          ModeFrameInc:     dout_d[ch*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(fcnt_eff);
          ModeLfsr:         dout_d[ch*DATA_WIDTH +: DATA_WIDTH] = lfsr_eff[DATA_WIDTH-1:0];
          default:          dout_d[ch*DATA_WIDTH +: DATA_WIDTH] = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fval_d1_q   <= 1'b0;
      lval_d1_q   <= 1'b0;
      fval_d2_q   <= 1'b0;
      lval_d2_q   <= 1'b0;
      prime_q     <= 1'b0;
      armed_q     <= 1'b0;
      mode_q      <= '0;
      skip_q      <= '0;
      line_cnt_q  <= '0;
      pix_cnt_q   <= '0;
      frm_pix_q   <= '0;
      frame_cnt_q <= '0;
      fcnt_lat_q  <= '0;
      dout_q      <= '0;
      for (int ch = 0; ch < int'(CHANNEL_NUM); ch++) lfsr_q[ch] <= '0;
    end else begin
      fval_d1_q   <= i_fval;
      lval_d1_q   <= i_lval;
      fval_d2_q   <= fval_d1_q;
      lval_d2_q   <= lval_d1_q;
      prime_q     <= prime_d;
      armed_q     <= armed_d;
      mode_q      <= mode_d;
      skip_q      <= skip_d;
      line_cnt_q  <= line_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      frm_pix_q   <= frm_pix_d;
      frame_cnt_q <= frame_cnt_d;
      fcnt_lat_q  <= fcnt_lat_d;
      dout_q      <= dout_d;
      for (int ch = 0; ch < int'(CHANNEL_NUM); ch++) lfsr_q[ch] <= lfsr_d[ch];
    end
  end

  assign o_fval       = fval_d2_q & armed_q;
  assign o_lval       = lval_d2_q & armed_q;
  assign ov_dout      = dout_q;
  assign ov_frame_cnt = frame_cnt_q;

endmodule
